// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator: the timing
// configuration record, the config-handshake state encoding and the
// legality check applied to every offered configuration.
package video_timing_pkg;

  // Field widths of the configuration record; the generator's counter width
  // parameters are expected to match these.
  localparam int CFG_H_BITS = 12;
  localparam int CFG_V_BITS = 11;

  typedef struct packed {
    logic [CFG_H_BITS-1:0] h_active;
    logic [CFG_H_BITS-1:0] h_fp;
    logic [CFG_H_BITS-1:0] h_sync;
    logic [CFG_H_BITS-1:0] h_bp;
    logic [CFG_V_BITS-1:0] v_active;
    logic [CFG_V_BITS-1:0] v_fp;
    logic [CFG_V_BITS-1:0] v_sync;
    logic [CFG_V_BITS-1:0] v_bp;
    logic                  hs_pol;
    logic                  vs_pol;
  } timing_cfg_t;

  typedef enum logic [0:0] {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_st_e;

  // Line length in pixels, two bits wider than a field so the sum cannot overflow.
  function automatic logic [CFG_H_BITS+1:0] h_total(input timing_cfg_t c);
    return {2'b00, c.h_active} + {2'b00, c.h_fp} + {2'b00, c.h_sync} + {2'b00, c.h_bp};
  endfunction

  // Frame height in lines, two bits wider than a field.
  function automatic logic [CFG_V_BITS+1:0] v_total(input timing_cfg_t c);
    return {2'b00, c.v_active} + {2'b00, c.v_fp} + {2'b00, c.v_sync} + {2'b00, c.v_bp};
  endfunction

  // A config is usable only if active and sync spans are non-empty and the
  // totals fit the counters (a total of exactly 2^bits still fits, since the
  // counter only reaches total-1).
  function automatic logic cfg_legal(input timing_cfg_t c);
    logic ok;
    ok = 1'b1;
    if ((c.h_active == {CFG_H_BITS{1'b0}}) || (c.h_sync == {CFG_H_BITS{1'b0}}) ||
        (c.v_active == {CFG_V_BITS{1'b0}}) || (c.v_sync == {CFG_V_BITS{1'b0}})) begin
      ok = 1'b0;
    end
    if (h_total(c) > {2'b01, {CFG_H_BITS{1'b0}}}) begin
      ok = 1'b0;
    end
    if (v_total(c) > {2'b01, {CFG_V_BITS{1'b0}}}) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis (used for both H and V): a wrapping position counter plus a
// decode of the position it moves to on this step. The decode is combinational
// so the parent can register it on the same edge as the counter itself,
// keeping the registered outputs aligned with the registered count.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [W+1:0] total,
  input  logic [W-1:0] active,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic [W+1:0] count_ext_s;
  logic [W+1:0] sync_start_s;
  logic [W+1:0] sync_end_s;

  assign count = count_r;

  // Terminal-count detect against the running total and next-position select.
  always_comb begin
    wrap        = ({2'b00, count_r} == (total - (W+2)'(1)));
    count_nxt_s = count_r;
    if (inc) begin
      if (wrap) begin
        count_nxt_s = {W{1'b0}};
      end else begin
        count_nxt_s = count_r + W'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Active/sync decode of the position the counter takes on this step.
  always_comb begin
    count_ext_s  = {2'b00, count_nxt_s};
    sync_start_s = {2'b00, active} + {2'b00, fp};
    sync_end_s   = sync_start_s + {2'b00, sync};
    in_active    = (count_ext_s < {2'b00, active});
    in_sync      = (count_ext_s >= sync_start_s) && (count_ext_s < sync_end_s);
  end

  // Position register; advances only when stepped.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      count_r <= count_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Run-time reprogrammable raster timing generator. New timing is accepted over
// a valid/ready port into a shadow set and swapped in only on the frame
// boundary pixel, so each frame is produced entirely with one timing set.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   HCNTR_BITS   = CFG_H_BITS,
  parameter int   VCNTR_BITS   = CFG_V_BITS,
  parameter int   FC_BITS      = 8,
  parameter int   DEF_H_ACTIVE = 1280,
  parameter int   DEF_H_FP     = 110,
  parameter int   DEF_H_SYNC   = 40,
  parameter int   DEF_H_BP     = 220,
  parameter int   DEF_V_ACTIVE = 720,
  parameter int   DEF_V_FP     = 5,
  parameter int   DEF_V_SYNC   = 5,
  parameter int   DEF_V_BP     = 20,
  parameter logic DEF_HS_POL   = 1'b1,
  parameter logic DEF_VS_POL   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pix_en_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  timing_cfg_t           cfg_i,
  output logic                  cfg_pending_o,
  output logic                  cfg_err_o,
  output logic [HCNTR_BITS-1:0] hcount_o,
  output logic [VCNTR_BITS-1:0] vcount_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  de_o,
  output logic                  sol_o,
  output logic                  sof_o,
  output logic [FC_BITS-1:0]    fc_o
);

  localparam timing_cfg_t DEF_CFG = '{
    h_active: CFG_H_BITS'(DEF_H_ACTIVE),
    h_fp:     CFG_H_BITS'(DEF_H_FP),
    h_sync:   CFG_H_BITS'(DEF_H_SYNC),
    h_bp:     CFG_H_BITS'(DEF_H_BP),
    v_active: CFG_V_BITS'(DEF_V_ACTIVE),
    v_fp:     CFG_V_BITS'(DEF_V_FP),
    v_sync:   CFG_V_BITS'(DEF_V_SYNC),
    v_bp:     CFG_V_BITS'(DEF_V_BP),
    hs_pol:   DEF_HS_POL,
    vs_pol:   DEF_VS_POL
  };

  cfg_st_e      state_r;
  cfg_st_e      state_nxt_s;
  timing_cfg_t  act_r;
  timing_cfg_t  shadow_r;
  timing_cfg_t  dec_cfg_s;
  logic         accept_s;
  logic         legal_s;
  logic         latch_s;
  logic         apply_s;
  logic         boundary_s;
  logic         v_inc_s;
  logic         h_wrap_s;
  logic         v_wrap_s;
  logic         h_act_s;
  logic         v_act_s;
  logic         h_sync_s;
  logic         v_sync_s;
  logic         ready_r;
  logic         pending_r;
  logic         err_r;
  logic         de_r;
  logic         hs_r;
  logic         vs_r;
  logic         sol_r;
  logic         sof_r;
  logic [FC_BITS-1:0] fc_r;

  assign v_inc_s    = pix_en_i & h_wrap_s;
  assign boundary_s = pix_en_i & h_wrap_s & v_wrap_s;

  video_axis_counter #(.W(HCNTR_BITS)) u_h (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (pix_en_i),
    .total     (h_total(act_r)),
    .active    (dec_cfg_s.h_active),
    .fp        (dec_cfg_s.h_fp),
    .sync      (dec_cfg_s.h_sync),
    .count     (hcount_o),
    .wrap      (h_wrap_s),
    .in_active (h_act_s),
    .in_sync   (h_sync_s)
  );

  video_axis_counter #(.W(VCNTR_BITS)) u_v (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (v_inc_s),
    .total     (v_total(act_r)),
    .active    (dec_cfg_s.v_active),
    .fp        (dec_cfg_s.v_fp),
    .sync      (dec_cfg_s.v_sync),
    .count     (vcount_o),
    .wrap      (v_wrap_s),
    .in_active (v_act_s),
    .in_sync   (v_sync_s)
  );

  // Config handshake: accept/reject offers when idle, swap shadow in at the boundary.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = cfg_valid_i & (state_r == CFG_IDLE);
    legal_s     = cfg_legal(cfg_i);
    latch_s     = 1'b0;
    apply_s     = 1'b0;
    case (state_r)
      CFG_IDLE: begin
        if (accept_s && legal_s) begin
          state_nxt_s = CFG_PENDING;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = CFG_IDLE;
        end
      end
      CFG_PENDING: begin
        if (boundary_s) begin
          state_nxt_s = CFG_IDLE;
          apply_s     = 1'b1;
        end else begin
          state_nxt_s = CFG_PENDING;
        end
      end
      default: begin
        state_nxt_s = CFG_IDLE;
      end
    endcase
  end

  // Timing set that the post-edge counter values are decoded against.
  always_comb begin
    dec_cfg_s = act_r;
    if (apply_s) begin
      dec_cfg_s = shadow_r;
    end else begin
      dec_cfg_s = act_r;
    end
  end

  // Config state, shadow/active timing sets and handshake status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= CFG_IDLE;
      act_r     <= DEF_CFG;
      shadow_r  <= DEF_CFG;
      ready_r   <= 1'b1;
      pending_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ready_r   <= (state_nxt_s == CFG_IDLE);
      pending_r <= (state_nxt_s == CFG_PENDING);
      err_r     <= accept_s & ~legal_s;
      if (latch_s) begin
        shadow_r <= cfg_i;
      end else begin
        shadow_r <= shadow_r;
      end
      if (apply_s) begin
        act_r <= shadow_r;
      end else begin
        act_r <= act_r;
      end
    end
  end

  // Decoded raster outputs and frame counter, registered with the counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_r  <= 1'b0;
      hs_r  <= ~DEF_CFG.hs_pol;
      vs_r  <= ~DEF_CFG.vs_pol;
      sol_r <= 1'b0;
      sof_r <= 1'b0;
      fc_r  <= {FC_BITS{1'b0}};
    end else if (pix_en_i) begin
      de_r  <= h_act_s & v_act_s;
      hs_r  <= h_sync_s ? dec_cfg_s.hs_pol : ~dec_cfg_s.hs_pol;
      vs_r  <= v_sync_s ? dec_cfg_s.vs_pol : ~dec_cfg_s.vs_pol;
      sol_r <= h_wrap_s;
      sof_r <= h_wrap_s & v_wrap_s;
      if (boundary_s) begin
        fc_r <= fc_r + FC_BITS'(1);
      end else begin
        fc_r <= fc_r;
      end
    end else begin
      de_r  <= de_r;
      hs_r  <= hs_r;
      vs_r  <= vs_r;
      sol_r <= sol_r;
      sof_r <= sof_r;
      fc_r  <= fc_r;
    end
  end

  assign cfg_ready_o   = ready_r;
  assign cfg_pending_o = pending_r;
  assign cfg_err_o     = err_r;
  assign de_o          = de_r;
  assign hs_o          = hs_r;
  assign vs_o          = vs_r;
  assign sol_o         = sol_r;
  assign sof_o         = sof_r;
  assign fc_o          = fc_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen. A frame-level reference model
// tracks the pixel index within the frame and derives column/line/syncs from
// it arithmetically; directed phases plus randomized pixel strobes and offers.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic        cfg_valid;
  timing_cfg_t cfg;
  logic        cfg_ready, cfg_pending, cfg_err;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic        hs, vs, de, sol, sof;
  logic [7:0]  fc;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  timing_cfg_t m_act, m_shadow;
  bit          m_pend, m_err, m_fresh;
  int          m_p, m_fc;

  timing_cfg_t cfg_a, cfg_b, cfg_def, cfg_x;

  always #5 clk = ~clk;

  video_timing_gen #(
    .HCNTR_BITS(12), .VCNTR_BITS(11), .FC_BITS(8),
    .DEF_H_ACTIVE(10), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(5),
    .DEF_V_ACTIVE(6), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(3),
    .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_i(cfg),
    .cfg_pending_o(cfg_pending), .cfg_err_o(cfg_err),
    .hcount_o(hcount), .vcount_o(vcount), .hs_o(hs), .vs_o(vs),
    .de_o(de), .sol_o(sol), .sof_o(sof), .fc_o(fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic timing_cfg_t mk(input int ha, hf, hsy, hb, va, vf, vsy, vb, input bit hp, vp);
    timing_cfg_t c;
    c.h_active = CFG_H_BITS'(ha); c.h_fp = CFG_H_BITS'(hf);
    c.h_sync = CFG_H_BITS'(hsy);  c.h_bp = CFG_H_BITS'(hb);
    c.v_active = CFG_V_BITS'(va); c.v_fp = CFG_V_BITS'(vf);
    c.v_sync = CFG_V_BITS'(vsy);  c.v_bp = CFG_V_BITS'(vb);
    c.hs_pol = hp; c.vs_pol = vp;
    return c;
  endfunction

  function automatic int htot(input timing_cfg_t c);
    return int'(c.h_active) + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
  endfunction

  function automatic int vtot(input timing_cfg_t c);
    return int'(c.v_active) + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
  endfunction

  function automatic bit legal(input timing_cfg_t c);
    if (c.h_active == 0 || c.h_sync == 0 || c.v_active == 0 || c.v_sync == 0) return 1'b0;
    if (htot(c) > 4096 || vtot(c) > 2048) return 1'b0;
    return 1'b1;
  endfunction

  // Model update for one clock edge, using the pre-edge model state.
  task automatic model_edge(input bit r, input bit pe, input bit v, input timing_cfg_t c);
    bit boundary, accept;
    if (r) begin
      m_act = cfg_def; m_shadow = cfg_def; m_pend = 0; m_err = 0;
      m_fresh = 1; m_p = 0; m_fc = 0;
      return;
    end
    boundary = pe && (m_p == htot(m_act) * vtot(m_act) - 1);
    accept   = v && !m_pend;
    m_err    = accept && !legal(c);
    if (m_pend && boundary) begin
      m_act = m_shadow; m_pend = 0;
    end else if (accept && legal(c)) begin
      m_shadow = c; m_pend = 1;
    end
    if (pe) begin
      m_fresh = 0;
      if (boundary) begin
        m_p = 0; m_fc = (m_fc + 1) % 256;
      end else begin
        m_p = m_p + 1;
      end
    end
  endtask

  task automatic compare_all();
    int ht, h, v, hs0, vs0;
    bit hsa, vsa;
    ht  = htot(m_act);
    h   = m_p % ht;
    v   = m_p / ht;
    hs0 = int'(m_act.h_active) + int'(m_act.h_fp);
    vs0 = int'(m_act.v_active) + int'(m_act.v_fp);
    hsa = (h >= hs0) && (h < hs0 + int'(m_act.h_sync));
    vsa = (v >= vs0) && (v < vs0 + int'(m_act.v_sync));
    check("hcount", hcount, h);
    check("vcount", vcount, v);
    check("fc", fc, m_fc);
    check("de", de, !m_fresh && h < int'(m_act.h_active) && v < int'(m_act.v_active));
    check("hs", hs, hsa ? m_act.hs_pol : !m_act.hs_pol);
    check("vs", vs, vsa ? m_act.vs_pol : !m_act.vs_pol);
    check("sol", sol, !m_fresh && h == 0);
    check("sof", sof, !m_fresh && m_p == 0);
    check("cfg_ready", cfg_ready, !m_pend);
    check("cfg_pending", cfg_pending, m_pend);
    check("cfg_err", cfg_err, m_err);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic tick(input bit r, input bit pe, input bit v, input timing_cfg_t c);
    rst = r; pix_en = pe; cfg_valid = v; cfg = c;
    @(posedge clk);
    model_edge(r, pe, v, c);
    @(negedge clk);
    compare_all();
  endtask

  // Step pixels (random density) until the pending config is applied.
  task automatic wait_applied(input string tag, input bit dense);
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(0, dense ? 1'b1 : ($urandom_range(0, 2) != 0), 0, cfg_a);
      if (!cfg_pending) begin ok = 1; break; end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int de_n, hs_n, vs_n, sof_n, prev_fc;
    bit ok, seen, done;
    cfg_def = mk(10, 2, 3, 5, 6, 1, 2, 3, 1'b1, 1'b0);
    cfg_a   = mk(8, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1);
    cfg_b   = mk(4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    rst = 1; pix_en = 0; cfg_valid = 0; cfg = cfg_def;
    @(negedge clk);

    // reset state
    tick(1, 0, 0, cfg_def);
    tick(1, 1, 1, cfg_a);
    check("rst_ready", cfg_ready, 1);
    check("rst_hs_idle", hs, 0);
    check("rst_vs_idle", vs, 1);
    check("rst_de", de, 0);

    // 1: load 16x8 timing, pixel every cycle
    tick(0, 0, 1, cfg_a);
    check("t1_pending", cfg_pending, 1);
    wait_applied("t1_apply", 1);
    check("t1_sof_at_apply", sof, 1);
    de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0;
    for (int i = 0; i < 128; i++) begin
      de_n += int'(de); hs_n += int'(hs); vs_n += int'(vs); sof_n += int'(sof);
      tick(0, 1, 0, cfg_a);
    end
    check("t1_de_per_frame", de_n, 32);
    check("t1_hs_per_frame", hs_n, 16);
    check("t1_vs_per_frame", vs_n, 16);
    check("t1_sof_per_frame", sof_n, 1);
    check("t1_sof_period", sof, 1);

    // 2: same timing, pixel every third cycle
    for (int i = 0; i < 780; i++) tick(0, (i % 3) == 0, 0, cfg_a);

    // 3: reprogram mid-frame at (3,2); old frame must finish unchanged
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick(0, 1, 0, cfg_a);
      if (hcount == 12'd3 && vcount == 11'd2) begin ok = 1; break; end
    end
    check("t3_reach_3_2", ok, 1);
    tick(0, 0, 1, cfg_b);
    check("t3_ready_drop", cfg_ready, 0);
    check("t3_pending", cfg_pending, 1);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(0, $urandom_range(0, 1), $urandom_range(0, 1), cfg_def);
      if (!cfg_pending) begin ok = 1; break; end
    end
    check("t3_apply", ok, 1);
    de_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 35; i++) begin
      de_n += int'(de); hs_n += int'(!hs); vs_n += int'(!vs);
      tick(0, 1, 0, cfg_a);
    end
    check("t3_de_per_frame", de_n, 8);
    check("t3_hs_low_per_frame", hs_n, 5);
    check("t3_vs_low_per_frame", vs_n, 7);

    // 4: illegal offers are consumed with an error pulse and nothing changes
    cfg_x = cfg_a; cfg_x.h_sync = '0;
    tick(0, 1, 1, cfg_x);
    check("t4_err_pulse", cfg_err, 1);
    tick(0, 1, 0, cfg_a);
    check("t4_err_clear", cfg_err, 0);
    check("t4_not_pending", cfg_pending, 0);
    tick(0, 1, 1, mk(4000, 50, 50, 0, 4, 1, 1, 2, 1, 1));
    check("t4_htot_over", cfg_err, 1);
    tick(0, 1, 1, mk(8, 2, 2, 4, 2000, 20, 20, 9, 1, 1));
    check("t4_vtot_over", cfg_err, 1);
    check("t4_still_idle", cfg_pending, 0);

    // 5: frame counter wraps 255 -> 0 -> 1
    tick(0, 1, 1, cfg_a);
    wait_applied("t5_apply", 0);
    seen = 0; done = 0;
    for (int i = 0; i < 50000 && !done; i++) begin
      prev_fc = int'(fc);
      tick(0, $urandom_range(0, 7) != 0, 0, cfg_a);
      if (prev_fc == 255 && fc != 8'hff) begin
        check("t5_fc_wrap_to_0", fc, 0);
        seen = 1;
      end else if (seen && fc == 8'd1) begin
        done = 1;
      end
    end
    check("t5_fc_wrap_seen", seen, 1);
    check("t5_fc_after_wrap", fc, 1);

    // randomized pixel strobes and config offers, legal and illegal
    for (int i = 0; i < 3000; i++) begin
      cfg_x = mk($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1));
      tick(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, cfg_x);
    end

    // 6: reset while a (max-width) config is pending mid-frame
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(0, 1, 0, cfg_a);
      if (!cfg_pending) begin ok = 1; break; end
    end
    check("t6_idle", ok, 1);
    tick(0, 1, 1, cfg_a);
    wait_applied("t6_apply_a", 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, cfg_a);
    tick(0, 1, 1, mk(4000, 40, 40, 16, 2, 1, 1, 1, 0, 0));
    check("t6_pending_big", cfg_pending, 1);
    tick(0, 1, 0, cfg_a);
    tick(1, 1, 0, cfg_a);
    check("t6_rst_hcount", hcount, 0);
    check("t6_rst_pending", cfg_pending, 0);
    check("t6_rst_ready", cfg_ready, 1);
    for (int i = 0; i < 300; i++) tick(0, 1, 0, cfg_a);
    check("t6_def_timing", hcount, 300 % 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
